// File: rtl/timer_counter_if.sv
// Register bus between the I/O bridge and timer device 0.
// Bridge drives the master side; the timer implements the slave side.
interface timer_counter_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic [1:0]       TMRAdd;
  logic             TMRWe;
  logic [WIDTH-1:0] TMRWD;
  logic [WIDTH-1:0] TMRRD;
  logic             TMRInt;

  modport master (
    output TMRAdd,
    output TMRWe,
    output TMRWD,
    input  TMRRD,
    input  TMRInt
  );

  modport slave (
    input  TMRAdd,
    input  TMRWe,
    input  TMRWD,
    output TMRRD,
    output TMRInt
  );
endinterface

// File: rtl/timer_counter.sv
// Timer device 0: down-counter with CTRL/PRESET/COUNT, one-shot and auto-reload modes.
// Optional prescaler (CTRL[7:4]) is enabled by defining TIMER_PRESCALE_EN.
module timer_counter #(
  parameter int unsigned WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  timer_counter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StIrq} state_e;

`ifdef TIMER_PRESCALE_EN
  localparam logic [7:0] CtrlMask = 8'hFF;
`else
  localparam logic [7:0] CtrlMask = 8'h0F;
`endif

  state_e           r_state, w_state_next;
  logic [7:0]       r_ctrl, w_ctrl_next;
  logic [WIDTH-1:0] r_preset, w_preset_next;
  logic [WIDTH-1:0] r_count, w_count_next;
  logic             r_pending, w_pending_next;
  logic             r_int;
  logic             w_ctrl_wr, w_preset_wr, w_step;

  assign w_ctrl_wr   = bus.TMRWe && (bus.TMRAdd == 2'd0);
  assign w_preset_wr = bus.TMRWe && (bus.TMRAdd == 2'd1);

`ifdef TIMER_PRESCALE_EN
  logic [3:0] r_ps, w_ps_next;
  assign w_step = (r_ps == r_ctrl[7:4]);
`else
  assign w_step = 1'b1;
`endif

  always_comb begin
    w_state_next   = r_state;
    w_ctrl_next    = r_ctrl;
    w_preset_next  = r_preset;
    w_count_next   = r_count;
    w_pending_next = r_pending;
`ifdef TIMER_PRESCALE_EN
    w_ps_next      = r_ps;
`endif

    if (w_ctrl_wr) begin
      w_ctrl_next = bus.TMRWD[7:0] & CtrlMask;
    end
    if (w_preset_wr) begin
      w_preset_next = bus.TMRWD;
    end

    // FSM decisions use the post-write EN so a CTRL write steers the very next state.
    case (r_state)
      StIdle: begin
        if (w_ctrl_next[0]) begin
          w_state_next = StLoad;
        end
      end
      StLoad: begin
        w_count_next = r_preset;
`ifdef TIMER_PRESCALE_EN
        w_ps_next    = 4'd0;
`endif
        w_state_next = w_ctrl_next[0] ? StCnt : StIdle;
      end
      StCnt: begin
        if (!w_ctrl_next[0]) begin
          w_state_next = StIdle;
        end else begin
`ifdef TIMER_PRESCALE_EN
          w_ps_next = w_step ? 4'd0 : r_ps + 4'd1;
`endif
          if (w_step) begin
            if (r_count > WIDTH'(1)) begin
              w_count_next = r_count - WIDTH'(1);
            end else begin
              w_count_next = '0;
              w_state_next = StIrq;
            end
          end
        end
      end
      StIrq: begin
        w_pending_next = 1'b1;
        if (w_ctrl_wr) begin
          w_state_next = w_ctrl_next[0] ? StLoad : StIdle;
        end else if (r_ctrl[2:1] == 2'b01) begin
          w_state_next = StLoad;
        end else begin
          w_ctrl_next[0] = 1'b0;
          w_state_next   = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase

    // A CTRL write always acknowledges, even against a same-cycle IRQ.
    if (w_ctrl_wr) begin
      w_pending_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_ctrl    <= 8'd0;
      r_preset  <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
      r_int     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_ctrl    <= w_ctrl_next;
      r_preset  <= w_preset_next;
      r_count   <= w_count_next;
      r_pending <= w_pending_next;
      r_int     <= w_pending_next & w_ctrl_next[3];
    end
  end

`ifdef TIMER_PRESCALE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ps <= 4'd0;
    end else begin
      r_ps <= w_ps_next;
    end
  end
`endif

  always_comb begin
    bus.TMRRD = '0;
    case (bus.TMRAdd)
      2'd0:    bus.TMRRD = {{(WIDTH-8){1'b0}}, r_ctrl};
      2'd1:    bus.TMRRD = r_preset;
      2'd2:    bus.TMRRD = r_count;
      default: bus.TMRRD = '0;
    endcase
  end

  assign bus.TMRInt = r_int;

endmodule
